// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end.
//   - PCSelector encodings driven by the control decoder.
//   - fetch_state_t: fetch-stage sequencing states.
//   - DEFAULT_RESET_PC: default fetch address after reset.
//   - branch_offset(): sign-extended, word-scaled branch displacement.
package cpu_pkg;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_REG    = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXECUTE = 2'd1,
      TRAP    = 2'd2
   } fetch_state_t;

   // Imm16 is a word offset: sign-extend then scale by 4.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   PC         in   current instruction address
//   Imm16      in   branch immediate (word offset)
//   Target26   in   jump target field Instruction[25:0]
//   RegRsData  in   rs value, jr target
//   PCSelector in   decoder choice of next PC source
//   NextPC     out  selected next PC (modulo 2^32)
//   PCPlus4    out  PC+4, also the jal link value
module next_pc_logic
   import cpu_pkg::*;
(
   input  logic [31:0] PC,
   input  logic [15:0] Imm16,
   input  logic [25:0] Target26,
   input  logic [31:0] RegRsData,
   input  logic [1:0]  PCSelector,
   output logic [31:0] NextPC,
   output logic [31:0] PCPlus4
);

   logic [31:0] pc_plus4;

   assign pc_plus4 = PC + 32'd4;
   assign PCPlus4  = pc_plus4;

   always_comb begin
      NextPC = pc_plus4;
      case (PCSelector)
         PC_SEQ:    NextPC = pc_plus4;
         PC_BRANCH: NextPC = pc_plus4 + branch_offset(Imm16);
         PC_REG:    NextPC = RegRsData;
         PC_JUMP:   NextPC = {pc_plus4[31:28], Target26, 2'b00};
         default:   NextPC = pc_plus4;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the MIPS core.
// Holds the PC, fetches one instruction per request/ready handshake, presents
// its fields to the decoder for one execute cycle, then advances the PC from
// the decoder's PCSelector. A misaligned next PC parks the stage in TRAP
// until reset.
// Ports:
//   Clock, ResetN            clock, asynchronous active-low reset
//   Hold                     freezes all state while high
//   IMemReady, IMemData      instruction memory response
//   PCSelector, RegRsData    next-PC control from decoder / register file
//   IMemRequest, IMemAddress instruction memory request
//   PC, PCPlus4              current address and its successor (link value)
//   Operator..Imm16          instruction fields
//   InstrValid               fields valid (execute cycle)
//   AddressError             sticky misaligned-target flag
//   RetireCount              retired instruction count (wraps)
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int unsigned COUNT_WIDTH = 32
) (
   input  logic                   Clock,
   input  logic                   ResetN,
   input  logic                   Hold,
   input  logic                   IMemReady,
   input  logic [31:0]            IMemData,
   input  logic [1:0]             PCSelector,
   input  logic [31:0]            RegRsData,
   output logic                   IMemRequest,
   output logic [31:0]            IMemAddress,
   output logic [31:0]            PC,
   output logic [31:0]            PCPlus4,
   output logic [5:0]             Operator,
   output logic [5:0]             Func,
   output logic [4:0]             Rs,
   output logic [4:0]             Rt,
   output logic [4:0]             Rd,
   output logic [4:0]             Shamt,
   output logic [15:0]            Imm16,
   output logic                   InstrValid,
   output logic                   AddressError,
   output logic [COUNT_WIDTH-1:0] RetireCount
);

   fetch_state_t           state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [31:0]            instr_q, instr_d;
   logic [COUNT_WIDTH-1:0] retire_q, retire_d;
   logic [31:0]            next_pc;

   next_pc_logic u_next_pc (
      .PC         (pc_q),
      .Imm16      (instr_q[15:0]),
      .Target26   (instr_q[25:0]),
      .RegRsData  (RegRsData),
      .PCSelector (PCSelector),
      .NextPC     (next_pc),
      .PCPlus4    (PCPlus4)
   );

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         instr_q  <= 32'h0000_0000;
         retire_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         retire_q <= retire_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      retire_d = retire_q;
      // Hold gates every transition, so a ready seen under Hold is dropped.
      if (!Hold) begin
         case (state_q)
            FETCH: begin
               if (IMemReady) begin
                  instr_d = IMemData;
                  state_d = EXECUTE;
               end
            end
            EXECUTE: begin
               pc_d     = next_pc;
               retire_d = retire_q + COUNT_WIDTH'(1);
               state_d  = (next_pc[1:0] != 2'b00) ? TRAP : FETCH;
            end
            TRAP: begin
               state_d = TRAP;
            end
            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

   // Reset forces the state to FETCH; gate the request so it is low while
   // ResetN is asserted rather than waking up already requesting.
   assign IMemRequest  = ResetN && (state_q == FETCH);
   assign InstrValid   = (state_q == EXECUTE);
   // TRAP is only left through reset, which makes this flag sticky.
   assign AddressError = (state_q == TRAP);

   assign IMemAddress = pc_q;
   assign PC          = pc_q;
   assign RetireCount = retire_q;

   assign Operator = instr_q[31:26];
   assign Rs       = instr_q[25:21];
   assign Rt       = instr_q[20:16];
   assign Rd       = instr_q[15:11];
   assign Shamt    = instr_q[10:6];
   assign Func     = instr_q[5:0];
   assign Imm16    = instr_q[15:0];

endmodule
